// File: rtl/axis_packet_collector.sv
// axis_packet_collector: parses header+data AXI-Stream packets, strobes good ones, publishes per-cycle index mask/count (optional duplicate tracking via AXIS_PACKET_COLLECTOR_DUP_CHECK_EN)
module axis_packet_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int MAGIC_WIDTH = 16,
  parameter int MAGIC_START_BIT = 16,
  parameter int INDEX_WIDTH = 5,
  parameter int INDEX_START_BIT = 10,
  parameter int NUM_DATA_WORDS = 1,
  parameter logic [MAGIC_WIDTH-1:0] EXPECTED_MAGIC = 16'hB6CF
) (
  input  logic sysClk,
  input  logic arst_n,
  input  logic newCycleStrobe,
  input  logic s_tvalid,
  output logic s_tready,
  input  logic s_tlast,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic packetStrobe,
  output logic [INDEX_WIDTH-1:0] packetIndex,
  output logic [DATA_WIDTH*NUM_DATA_WORDS-1:0] packetData,
  output logic statusStrobe,
  output logic [1:0] statusCode,
  output logic cycleStrobe,
  output logic [2**INDEX_WIDTH-1:0] cycleMask,
  output logic [7:0] cycleCount
`ifdef AXIS_PACKET_COLLECTOR_DUP_CHECK_EN
  ,
  output logic dupStrobe,
  output logic [7:0] dupCount
`endif
);
  localparam int MASK_W = 2**INDEX_WIDTH;
  localparam int CW = NUM_DATA_WORDS > 1 ? $clog2(NUM_DATA_WORDS) : 1;
  typedef enum logic [1:0] {ST_HEADER, ST_DATA, ST_DRAIN} state_t;
  state_t r_state;
  logic [CW-1:0] r_wcnt;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [NUM_DATA_WORDS-1:0][DATA_WIDTH-1:0] r_buf;
  logic [MASK_W-1:0] r_mask_acc;
  logic [7:0] r_count_acc;
  logic w_beat, w_magic_ok, w_last_word, w_success;
  logic [INDEX_WIDTH-1:0] w_hdr_index;
  logic [MASK_W-1:0] w_bit;
  logic [NUM_DATA_WORDS-1:0][DATA_WIDTH-1:0] w_buf_next;
`ifdef AXIS_PACKET_COLLECTOR_DUP_CHECK_EN
  logic w_dup;
`endif
  // beat decode; the payload image includes the current beat so success can publish it without a bubble
  always_comb begin
    w_beat = s_tvalid && s_tready;
    w_magic_ok = s_tdata[MAGIC_START_BIT +: MAGIC_WIDTH] == EXPECTED_MAGIC;
    w_hdr_index = s_tdata[INDEX_START_BIT +: INDEX_WIDTH];
    w_last_word = r_wcnt == CW'(NUM_DATA_WORDS-1);
    w_success = w_beat && r_state == ST_DATA && w_last_word && s_tlast;
    w_bit = {{(MASK_W-1){1'b0}}, 1'b1} << r_index;
    w_buf_next = r_buf;
    w_buf_next[r_wcnt] = s_tdata;
`ifdef AXIS_PACKET_COLLECTOR_DUP_CHECK_EN
    w_dup = w_success && !newCycleStrobe && r_mask_acc[r_index];
`endif
  end
  // packet parser FSM with registered packet/status outputs
  always_ff @(posedge sysClk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_HEADER;
      r_wcnt <= '0;
      r_index <= '0;
      r_buf <= '0;
      s_tready <= 1'b0;
      packetStrobe <= 1'b0;
      packetIndex <= '0;
      packetData <= '0;
      statusStrobe <= 1'b0;
      statusCode <= 2'd0;
    end else begin
      s_tready <= 1'b1;
      packetStrobe <= 1'b0;
      statusStrobe <= 1'b0;
      if (w_beat) begin
        case (r_state)
          ST_HEADER: begin
            if (!w_magic_ok) begin
              statusStrobe <= 1'b1;
              statusCode <= 2'd1;
              r_state <= s_tlast ? ST_HEADER : ST_DRAIN;
            end else if (s_tlast) begin
              statusStrobe <= 1'b1;
              statusCode <= 2'd2;
            end else begin
              r_index <= w_hdr_index;
              r_wcnt <= '0;
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_buf <= w_buf_next;
            r_wcnt <= r_wcnt + 1'b1;
            if (s_tlast || w_last_word) begin
              statusStrobe <= 1'b1;
              statusCode <= !w_last_word ? 2'd2 : s_tlast ? 2'd0 : 2'd3;
              r_state <= (w_last_word && !s_tlast) ? ST_DRAIN : ST_HEADER;
            end
            if (w_success) begin
              packetStrobe <= 1'b1;
              packetIndex <= r_index;
              packetData <= w_buf_next;
            end
          end
          default: r_state <= s_tlast ? ST_HEADER : ST_DRAIN;
        endcase
      end
    end
  end
  // per-cycle accumulators; a success on the boundary cycle seeds the new cycle
  always_ff @(posedge sysClk or negedge arst_n) begin
    if (!arst_n) begin
      r_mask_acc <= '0;
      r_count_acc <= '0;
      cycleStrobe <= 1'b0;
      cycleMask <= '0;
      cycleCount <= '0;
`ifdef AXIS_PACKET_COLLECTOR_DUP_CHECK_EN
      dupStrobe <= 1'b0;
      dupCount <= '0;
`endif
    end else begin
      cycleStrobe <= newCycleStrobe;
      if (newCycleStrobe) begin
        cycleMask <= r_mask_acc;
        cycleCount <= r_count_acc;
      end
      r_mask_acc <= (newCycleStrobe ? '0 : r_mask_acc) | (w_success ? w_bit : '0);
      r_count_acc <= newCycleStrobe ? {7'd0, w_success} : r_count_acc + {7'd0, w_success && r_count_acc != 8'hFF};
`ifdef AXIS_PACKET_COLLECTOR_DUP_CHECK_EN
      dupStrobe <= w_dup;
      dupCount <= newCycleStrobe ? 8'd0 : dupCount + {7'd0, w_dup && dupCount != 8'hFF};
`endif
    end
  end
endmodule

// File: doc/axis_packet_collector.md
Name: axis_packet_collector

Overview:
- Consumes the single merged AXI-Stream produced by axisMux in the sysClk domain.
- Parses each packet as one header word plus NUM_DATA_WORDS data words and validates the header magic.
- Emits one packet strobe per valid packet and tracks which indices arrived during each FA cycle.
- On every FA cycle boundary (newCycleStrobe), publishes the received-index mask and the packet count for the cycle just closed.

Parameters:
- DATA_WIDTH, 32, stream word width.
- MAGIC_WIDTH, 16, header magic field width.
- MAGIC_START_BIT, 16, LSB of the magic field in the header.
- INDEX_WIDTH, 5, packet index field width; the mask is 2**INDEX_WIDTH bits wide.
- INDEX_START_BIT, 10, LSB of the index field in the header.
- NUM_DATA_WORDS, 1, data words per packet (range 1..8).
- EXPECTED_MAGIC, 16'hB6CF, required header magic value.

Ports:
- sysClk  in  1  clock.
- arst_n  in  1  asynchronous, active-low reset.
- newCycleStrobe  in  1  single-cycle FA cycle boundary pulse.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready.
- s_tlast  in  1  stream last.
- s_tdata  in  DATA_WIDTH  stream data.
- packetStrobe  out  1  one-cycle pulse: valid packet complete.
- packetIndex  out  INDEX_WIDTH  index of the last valid packet.
- packetData  out  DATA_WIDTH*NUM_DATA_WORDS  payload; word 0 in the LSBs.
- statusStrobe  out  1  one-cycle pulse at the end of every packet, good or bad.
- statusCode  out  2  0 OK, 1 bad magic, 2 short packet, 3 long packet.
- cycleStrobe  out  1  one cycle after newCycleStrobe.
- cycleMask  out  2**INDEX_WIDTH  indices received in the closed cycle.
- cycleCount  out  8  valid packets in the closed cycle; saturates at 255.

Behaviour:
- Reset: all outputs 0; s_tready 0 while arst_n is low; FSM to ST_HEADER; accumulators cleared. Reset mid-packet discards the partial packet and produces no strobes.
- s_tready is 1 in every cycle after reset release. A beat transfers only when s_tvalid && s_tready. No backpressure is generated.
- ST_HEADER, on a beat:
  - Magic mismatch: status 1. If s_tlast is 0, go to ST_DRAIN; if s_tlast is 1, stay.
  - Magic matches and s_tlast=1: status 2 (short packet).
  - Magic matches and s_tlast=0: latch the index, clear the word counter, go to ST_DATA.
- ST_DATA: store each beat at the word-counter slot.
  - s_tlast=1 before word NUM_DATA_WORDS-1: status 2, go to ST_HEADER.
  - Word NUM_DATA_WORDS-1 with s_tlast=1: success, go to ST_HEADER.
  - Word NUM_DATA_WORDS-1 with s_tlast=0: status 3, go to ST_DRAIN.
- ST_DRAIN: discard beats until one with s_tlast, then go to ST_HEADER. No further status is issued.
- Latency:
  - On success, packetStrobe, packetIndex, packetData and statusStrobe with code 0 are registered and appear 1 cycle after the final beat.
  - Error status appears 1 cycle after the offending beat.
  - packetIndex and packetData hold their values until the next success.
- Accumulators:
  - Each success sets the mask bit for its index and increments the count, saturating at 255.
  - A repeated index counts again but does not change the mask.
- newCycleStrobe:
  - Next cycle: cycleMask and cycleCount take the accumulator values and cycleStrobe pulses.
  - The accumulators clear in that same update.
  - A success coinciding with newCycleStrobe belongs to the new cycle: accumulators restart with only that packet.
- Back-to-back packets with no idle beats must be handled; the FSM never inserts a bubble.

Optional Feature:
- Macro: AXIS_PACKET_COLLECTOR_DUP_CHECK_EN.
- With the macro defined:
  - Adds output dupStrobe (1 bit) and output dupCount (8 bits, saturating, cleared on each newCycleStrobe update).
  - A success whose index is already set in the current accumulator pulses dupStrobe alongside packetStrobe and increments dupCount.
  - cycleCount still counts the packet.
- Without the macro: the ports are absent and duplicates are silently counted.

Test Plan:
- Packets with indices 0..3, header 0xB6CF0000|(idx<<10), data 0x00CACA01, tlast on the data word; then newCycleStrobe. Required: 4 packetStrobes with matching index/data, cycleMask=0x0000000F, cycleCount=4.
- Header magic 0xB6CE, then a valid packet with index 7. Required: statusCode 1 once, then a success for index 7 with no lost beats.
- Header with tlast=1 → status 2. Then a 3-word packet with NUM_DATA_WORDS=1 → status 3, and the drain ends on tlast. Required: the following valid packet is accepted.
- newCycleStrobe asserted in the same cycle a packet with index 5 completes. Required: closed cycleMask excludes bit 5, next cycleMask has bit 5, cycleCount=1.
- arst_n low for 3 cycles while in ST_DATA. Required: no strobes, s_tready=0, all outputs 0; a full packet after release succeeds.
- With AXIS_PACKET_COLLECTOR_DUP_CHECK_EN defined: index 2 sent twice in one cycle. Required: dupStrobe on the second packet, dupCount=1, cycleCount=2, cycleMask=0x4.
